// File: rtl/oq_rr_scheduler.sv
// Round-robin removal scheduler for the output-queue SRAM: grants one eligible queue at a time
// and holds the grant until the remove engine reports the packet read. Optional watchdog: OQ_SCHED_WATCHDOG_EN.
module oq_rr_scheduler #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int WATCHDOG_CYCLES   = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_OUTPUT_QUEUES-1:0] pkt_avail,
    input  logic [NUM_OUTPUT_QUEUES-1:0] port_ready,
    input  logic [NUM_OUTPUT_QUEUES-1:0] enable,
    input  logic                         pause,
    output logic                         rd_req,
    output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
    input  logic                         rd_ack,
    input  logic                         rd_done,
    output logic                         busy,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [NUM_OQ_WIDTH-1:0] LAST_Q = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);

    if ((NUM_OUTPUT_QUEUES < 2) || (WATCHDOG_CYCLES < 2)) begin : g_bad_cfg
        $error("oq_rr_scheduler: NUM_OUTPUT_QUEUES and WATCHDOG_CYCLES must both be at least 2");
    end

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [NUM_OUTPUT_QUEUES-1:0]   eligible_s;
    logic                           any_elig_s;
    logic                           found_hi_s;
    logic [NUM_OQ_WIDTH-1:0]        sel_hi_s;
    logic [NUM_OQ_WIDTH-1:0]        sel_lo_s;
    logic [NUM_OQ_WIDTH-1:0]        sel_s;
    logic [NUM_OQ_WIDTH-1:0]        rr_ptr_r;
    logic [NUM_OQ_WIDTH-1:0]        ptr_inc_s;
    logic [NUM_OQ_WIDTH-1:0]        rd_oq_r;
    logic                           rd_req_r;
    logic                           rd_req_nxt_s;
    logic                           busy_r;
    logic                           busy_nxt_s;
    logic                           load_oq_s;
    logic                           exit_s;
`ifdef OQ_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(WATCHDOG_CYCLES - 1);
    logic [15:0]                    wd_cnt_r;
    logic                           wd_fire_s;
    logic                           timeout_err_r;
`endif

    // Eligibility and round-robin pick: lowest eligible index at or above rr_ptr, else lowest overall
    always_comb begin
        eligible_s = pkt_avail & port_ready & enable & {NUM_OUTPUT_QUEUES{~pause}};
        any_elig_s = |eligible_s;
        found_hi_s = 1'b0;
        sel_hi_s   = {NUM_OQ_WIDTH{1'b0}};
        sel_lo_s   = {NUM_OQ_WIDTH{1'b0}};
        // Descending scan so the lowest matching index is the last one written
        for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
            sel_lo_s   = eligible_s[i] ? NUM_OQ_WIDTH'(i) : sel_lo_s;
            sel_hi_s   = (eligible_s[i] && (i >= int'(rr_ptr_r))) ? NUM_OQ_WIDTH'(i) : sel_hi_s;
            found_hi_s = (eligible_s[i] && (i >= int'(rr_ptr_r))) ? 1'b1 : found_hi_s;
        end
        sel_s = found_hi_s ? sel_hi_s : sel_lo_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; exit_s marks every return to IDLE that advances the pointer
    always_comb begin
        state_nxt_s = state_r;
        exit_s      = 1'b0;
`ifdef OQ_SCHED_WATCHDOG_EN
        wd_fire_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (any_elig_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_ack && rd_done) begin
                    state_nxt_s = ST_IDLE;
                    exit_s      = 1'b1;
                end else if (rd_ack) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rd_done) begin
                    state_nxt_s = ST_IDLE;
                    exit_s      = 1'b1;
`ifdef OQ_SCHED_WATCHDOG_EN
                end else if (wd_cnt_r == WD_LIMIT) begin
                    state_nxt_s = ST_IDLE;
                    exit_s      = 1'b1;
                    wd_fire_s   = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered outputs and the pointer successor
    always_comb begin
        rd_req_nxt_s = (state_nxt_s == ST_REQ);
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        load_oq_s    = (state_r == ST_IDLE) && any_elig_s;
        if (rd_oq_r == LAST_Q) begin
            ptr_inc_s = {NUM_OQ_WIDTH{1'b0}};
        end else begin
            ptr_inc_s = rd_oq_r + NUM_OQ_WIDTH'(1'b1);
        end
    end

    // Registered outputs, granted queue and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_req_r <= 1'b0;
            busy_r   <= 1'b0;
            rd_oq_r  <= {NUM_OQ_WIDTH{1'b0}};
            rr_ptr_r <= {NUM_OQ_WIDTH{1'b0}};
        end else begin
            rd_req_r <= rd_req_nxt_s;
            busy_r   <= busy_nxt_s;
            if (load_oq_s) begin
                rd_oq_r <= sel_s;
            end
            if (exit_s) begin
                rr_ptr_r <= ptr_inc_s;
            end
        end
    end

`ifdef OQ_SCHED_WATCHDOG_EN
    // Watchdog counter: cleared on entry to WAIT, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r      <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= wd_fire_s;
            if ((state_r == ST_REQ) && (state_nxt_s == ST_WAIT)) begin
                wd_cnt_r <= 16'd0;
            end else if (state_r == ST_WAIT) begin
                wd_cnt_r <= wd_cnt_r + 16'd1;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign rd_req = rd_req_r;
    assign rd_oq  = rd_oq_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_oq_rr_scheduler.sv
// Scoreboard bench for oq_rr_scheduler: directed stimulus pushes expected grants, a monitor
// pops and compares them on every rd_req/rd_ack handshake.
module tb_oq_rr_scheduler;

    localparam int NQ = 8;
    localparam int W  = 3;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NQ-1:0] pkt_avail;
    logic [NQ-1:0] port_ready;
    logic [NQ-1:0] enable;
    logic          pause;
    logic          rd_req;
    logic [W-1:0]  rd_oq;
    logic          rd_ack;
    logic          rd_done;
    logic          busy;
    logic          timeout_err;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  exp_q[$];

    // Remove-engine model controls
    int            ack_delay  = 0;
    int            done_delay = 0;
    bit            no_done    = 1'b0;

    oq_rr_scheduler #(
        .NUM_OUTPUT_QUEUES (NQ),
        .NUM_OQ_WIDTH      (W),
        .WATCHDOG_CYCLES   (WD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_avail   (pkt_avail),
        .port_ready  (port_ready),
        .enable      (enable),
        .pause       (pause),
        .rd_req      (rd_req),
        .rd_oq       (rd_oq),
        .rd_ack      (rd_ack),
        .rd_done     (rd_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((exp_q.size() != 0) && (k < max_cycles)) begin
            step();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d grants still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Remove-engine responder: acks after ack_delay REQ cycles, signals done done_delay WAIT cycles later
    initial begin : responder
        int req_cnt;
        int wait_cnt;
        bit in_wait;
        req_cnt  = 0;
        wait_cnt = 0;
        in_wait  = 1'b0;
        rd_ack   = 1'b0;
        rd_done  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_ack  = 1'b0;
            rd_done = 1'b0;
            if (reset) begin
                req_cnt = 0;
                in_wait = 1'b0;
            end else if (rd_req) begin
                if (req_cnt == ack_delay) begin
                    rd_ack  = 1'b1;
                    req_cnt = 0;
                    if (!no_done && (done_delay == 0)) begin
                        rd_done = 1'b1;
                        in_wait = 1'b0;
                    end else begin
                        in_wait  = 1'b1;
                        wait_cnt = done_delay;
                    end
                end else begin
                    req_cnt++;
                end
            end else if (in_wait && busy) begin
                if (!no_done) begin
                    wait_cnt--;
                    if (wait_cnt <= 0) begin
                        rd_done = 1'b1;
                        in_wait = 1'b0;
                    end
                end
            end else begin
                in_wait = 1'b0;
            end
        end
    end

    // Monitor: every accepted request is compared against the next expected grant
    initial begin : monitor
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && rd_req && rd_ack) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_grant: got queue %0d, expected none", rd_oq);
                end else begin
                    exp = exp_q.pop_front();
                    if (rd_oq !== exp) begin
                        n_errors++;
                        $display("FAIL grant_order: got queue %0d, expected %0d", rd_oq, exp);
                    end
                end
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int len;
        bit stable;
        int hits;

        reset      = 1'b1;
        pkt_avail  = 8'hFF;
        port_ready = 8'hFF;
        enable     = 8'hFF;
        pause      = 1'b0;
        repeat (3) step();
        check("reset_rd_req", 32'(rd_req), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_oq", 32'(rd_oq), 32'd0);
        check("reset_timeout_err", 32'(timeout_err), 32'd0);

        // All eligible, immediate ack+done: 0..7 then wrap to 0
        reset = 1'b0;
        for (int i = 0; i < NQ; i++) exp_q.push_back(W'(i));
        exp_q.push_back(3'd0);
        step();
        check("first_grant_rd_req", 32'(rd_req), 32'd1);
        check("first_grant_rd_oq", 32'(rd_oq), 32'd0);
        drain(60);
        pkt_avail = 8'h00;
        step();
        step();
        check("idle_after_sweep_busy", 32'(busy), 32'd0);

        // Move pointer to 3, then alternate between queues 7 and 2
        pkt_avail = 8'b0000_0100;
        exp_q.push_back(3'd2);
        drain(20);
        pkt_avail = 8'b1000_0100;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd7);
        drain(30);
        pkt_avail = 8'h00;
        step();

        // Queue 7 blocked by its transmit path: only queue 2 is ever granted
        port_ready = 8'b0111_1111;
        pkt_avail  = 8'b1000_0100;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        drain(30);
        pkt_avail = 8'h00;
        repeat (2) step();
        port_ready = 8'hFF;

        // Ack withheld 5 cycles: rd_req held 6 cycles on a constant queue, then WAIT
        ack_delay  = 5;
        done_delay = 2;
        pkt_avail  = 8'b0001_0000;
        exp_q.push_back(3'd4);
        step();
        pkt_avail = 8'h00;
        len       = 0;
        stable    = 1'b1;
        for (int k = 0; (k < 20) && rd_req; k++) begin
            len++;
            if (rd_oq !== 3'd4) stable = 1'b0;
            step();
        end
        check("req_hold_cycles", 32'(len), 32'd6);
        check("req_hold_rd_oq_stable", 32'(stable), 32'd1);
        check("wait_busy", 32'(busy), 32'd1);
        repeat (4) step();
        check("wait_done_busy", 32'(busy), 32'd0);

        // Ack and done together: straight back to IDLE
        ack_delay  = 0;
        done_delay = 0;
        pkt_avail  = 8'b0010_0000;
        exp_q.push_back(3'd5);
        step();
        check("ackdone_rd_req", 32'(rd_req), 32'd1);
        pkt_avail = 8'h00;
        step();
        check("ackdone_skips_wait_busy", 32'(busy), 32'd0);

        // Pause blocks all grants; release grants from rr_ptr = 6
        pause     = 1'b1;
        pkt_avail = 8'hFF;
        hits      = 0;
        repeat (20) begin
            step();
            if (rd_req) hits++;
        end
        check("pause_no_rd_req", 32'(hits), 32'd0);
        pause = 1'b0;
        exp_q.push_back(3'd6);
        step();
        check("unpause_rd_req", 32'(rd_req), 32'd1);
        check("unpause_rd_oq", 32'(rd_oq), 32'd6);
        pkt_avail = 8'h00;
        step();

        // Reset while waiting on queue 5: pointer returns to 0
        no_done   = 1'b1;
        pkt_avail = 8'b0010_0000;
        exp_q.push_back(3'd5);
        step();
        pkt_avail = 8'h00;
        repeat (4) step();
        check("wait_q5_busy", 32'(busy), 32'd1);
        check("wait_q5_rd_req", 32'(rd_req), 32'd0);
        check("wait_q5_rd_oq", 32'(rd_oq), 32'd5);
        reset = 1'b1;
        step();
        check("midreset_rd_req", 32'(rd_req), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        reset     = 1'b0;
        no_done   = 1'b0;
        pkt_avail = 8'hFF;
        exp_q.push_back(3'd0);
        drain(20);
        pkt_avail = 8'h00;
        repeat (2) step();

        // Engine never reports done on queue 3
        no_done   = 1'b1;
        pkt_avail = 8'b0000_1000;
        exp_q.push_back(3'd3);
        step();
        pkt_avail = 8'h00;
`ifdef OQ_SCHED_WATCHDOG_EN
        begin
            int  waits;
            bit  seen;
            waits = 0;
            seen  = 1'b0;
            for (int k = 0; (k < 60) && !seen; k++) begin
                step();
                if (busy && !rd_req) waits++;
                if (timeout_err) seen = 1'b1;
            end
            check("watchdog_fired", 32'(seen), 32'd1);
            check("watchdog_wait_cycles", 32'(waits), 32'd16);
            no_done   = 1'b0;
            pkt_avail = 8'hFF;
            exp_q.push_back(3'd4);
            drain(20);
            pkt_avail = 8'h00;
            hits      = 0;
            repeat (20) begin
                step();
                if (timeout_err) hits++;
            end
            check("watchdog_single_pulse", 32'(hits), 32'd0);
        end
`else
        hits = 0;
        repeat (30) begin
            step();
            if (timeout_err) hits++;
        end
        check("no_watchdog_timeout_err", 32'(hits), 32'd0);
        check("no_watchdog_still_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        no_done = 1'b0;
        step();
        check("no_watchdog_reset_busy", 32'(busy), 32'd0);
`endif

        repeat (3) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
